// File: rtl/popcount_sequencer.sv
// popcount_sequencer: counts the ones in a WIDTH-bit word, one byte slice per
// clock (LSB slice first), through a single shared 8-bit count_ones datapath.
// Producer side and consumer side are both valid/ready.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. in_ready and out_valid are decoded from the
// registered state only, so neither depends combinationally on any input.
// A raised valid is never withdrawn by this block before its transfer, except
// when clear or reset discards the job.

// count_ones: combinational population count of one byte.
module count_ones (
  input  logic [7:0] din,
  output logic [3:0] ones
);

  // Sum the eight bits of the byte.
  always_comb begin
    ones = '0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'b000, din[i]};
    end
  end

endmodule

module popcount_sequencer #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 8;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // The slice scheme only works on whole bytes.
  if (((WIDTH % 8) != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("popcount_sequencer: WIDTH (%0d) must be a multiple of 8 and >= 8", WIDTH);
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] word_q;
  logic [CNT_W-1:0] acc_q;
  logic [IDX_W-1:0] idx_q;

  logic [7:0]       slice;
  logic [3:0]       slice_ones;
  logic [CNT_W-1:0] acc_next;
  logic             last_slice;

  // Select the byte slice addressed by the current index.
  always_comb begin
    slice = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slice = word_q[8*i +: 8];
      end
    end
  end

  count_ones u_count_ones (
    .din  (slice),
    .ones (slice_ones)
  );

  // Accumulator cannot overflow: the largest possible sum is WIDTH.
  assign acc_next   = acc_q + CNT_W'(slice_ones);
  assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

  // Status outputs are pure decodes of the registered state.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

  // Control FSM: accept a word, walk its slices, hold the result until taken.
  // clear overrides every other transition in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      out_count <= '0;
    end else if (clear) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      idx_q     <= '0;
      out_count <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            word_q  <= in_data;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q <= acc_next;
          idx_q <= idx_q + 1'b1;
          if (last_slice) begin
            out_count <= acc_next;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_sequencer.sv
// tb_popcount_sequencer: directed bench for popcount_sequencer (WIDTH=32).
module tb_popcount_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_count;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  popcount_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one job: accept, check latency, check result, hand it off.
  task automatic run_job(input logic [31:0] data, input logic [5:0] exp, input string name);
    int lat;
    lat = 0;
    while (!in_ready && lat < 20) begin
      tick();
      lat++;
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d want 4", name, lat);
    end
    tests_run++;
    if (out_count !== exp) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d want %0d", name, out_count, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_post: in_ready=%b out_valid=%b busy=%b want 1 0 0",
               name, in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_count !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_count=%0d want 1 0 0 0",
               in_ready, out_valid, busy, out_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_patterns();
    run_job(32'hFFFF_FFFF, 6'd32, "all_ones");
    run_job(32'h0000_0000, 6'd0,  "all_zero");
    run_job(32'h8000_0001, 6'd2,  "end_bits");
    run_job(32'hF0F0_00FF, 6'd16, "mixed");
  endtask

  task automatic test_stall();
    int n;
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    in_data  = 32'hFFFF_FFFF;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_count !== 6'd13 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: out_valid=%b out_count=%0d in_ready=%b want 1 13 0",
                 i, out_valid, out_count, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_clear();
    int seen;
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_count !== 6'd0) begin
      tests_failed++;
      $display("FAIL clear_run: in_ready=%b busy=%b out_count=%0d want 1 0 0",
               in_ready, busy, out_count);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL clear_no_valid: out_valid seen %0d cycles want 0", seen);
    end
    // clear in IDLE blocks an offered word
    in_valid = 1'b1;
    in_data  = 32'h0000_00FF;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_idle: in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
    run_job(32'h0000_0F0F, 6'd8, "after_clear");
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_count !== 6'd0) begin
      tests_failed++;
      $display("FAIL async_reset: in_ready=%b busy=%b out_valid=%b out_count=%0d want 1 0 0 0",
               in_ready, busy, out_valid, out_count);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_release: out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
    run_job(32'hAAAA_AAAA, 6'd16, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    int acc_cyc;
    int hs_cyc;
    int n;
    words[0] = 32'h0000_0001;
    words[1] = 32'h0000_0003;
    words[2] = 32'h0000_0007;
    hs_cyc    = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = words[0];
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready);
      end
      tick();
      acc_cyc = cyc;
      in_data = 32'hFFFF_FFFF;
      if (i > 0) begin
        tests_run++;
        if (acc_cyc !== hs_cyc + 1) begin
          tests_failed++;
          $display("FAIL b2b_accept%0d: accept cycle %0d want %0d", i, acc_cyc, hs_cyc + 1);
        end
      end
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      tests_run++;
      if (out_valid !== 1'b1 || out_count !== 6'(i + 1)) begin
        tests_failed++;
        $display("FAIL b2b_count%0d: out_valid=%b out_count=%0d want 1 %0d",
                 i, out_valid, out_count, i + 1);
      end
      tick();
      hs_cyc = cyc;
      if (i < 2) in_data = words[i + 1];
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_end: busy=%b in_ready=%b want 0 1", busy, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_stall();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
